// File: rtl/niosattempt_cpu_mul_combine_if.sv
// rtl/niosattempt_cpu_mul_combine_if.sv - handshake bundle between multiplier cell, combiner and writeback
interface niosattempt_cpu_mul_combine_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_p1;
  logic [31:0] in_p2;
  logic [31:0] in_p3;
  logic [31:0] in_p4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  modport master (
    output in_valid, in_op, in_p1, in_p2, in_p3, in_p4, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_p1, in_p2, in_p3, in_p4, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/niosattempt_cpu_mul_combine.sv
// rtl/niosattempt_cpu_mul_combine.sv - sums 16x16 partial products into a 32-bit mul/mulxuu result word
// Optional high-word path (HI state, in_p4, in_op) enabled by MUL_HIGH_EN.
module niosattempt_cpu_mul_combine (
  input logic                           clk,
  input logic                           reset,
  niosattempt_cpu_mul_combine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, OUT} state_t;

  state_t state, state_next;
  logic   accept;

  logic [31:0] p1_q;
  logic [31:0] lo_q;
  logic [32:0] mid_d;

  assign mid_d  = {1'b0, bus.in_p2} + {1'b0, bus.in_p3};
  assign accept = bus.in_valid && bus.in_ready;

`ifdef MUL_HIGH_EN
  logic        op_q;
  logic        cy_q;
  logic [31:0] p4_q;
  logic [31:0] hi_q;
  logic [32:0] mid_q;
  logic [32:0] low_sum;

  assign low_sum = {1'b0, p1_q} + {1'b0, mid_q[15:0], 16'h0};
`else
  logic [15:0] mid_q;
  logic [31:0] low_sum;
  logic        unused_ok;

  // Only the low word is ever produced, so the carry chain into the top half is dropped.
  assign low_sum   = p1_q + {mid_q, 16'h0};
  assign unused_ok = ^{bus.in_op, bus.in_p4, mid_d[32:16]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = LO;
`ifdef MUL_HIGH_EN
      LO:   state_next = op_q ? HI : OUT;
      HI:   state_next = OUT;
`else
      LO:   state_next = OUT;
      HI:   state_next = OUT;
`endif
      OUT: begin
        if (bus.out_ready) begin
          state_next = accept ? LO : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q  <= '0;
      mid_q <= '0;
      lo_q  <= '0;
`ifdef MUL_HIGH_EN
      op_q  <= 1'b0;
      cy_q  <= 1'b0;
      p4_q  <= '0;
      hi_q  <= '0;
`endif
    end else begin
      if (accept) begin
        p1_q  <= bus.in_p1;
`ifdef MUL_HIGH_EN
        mid_q <= mid_d;
        op_q  <= bus.in_op;
        p4_q  <= bus.in_p4;
`else
        mid_q <= mid_d[15:0];
`endif
      end
      if (state == LO) begin
        lo_q <= low_sum[31:0];
`ifdef MUL_HIGH_EN
        cy_q <= low_sum[32];
`endif
      end
`ifdef MUL_HIGH_EN
      if (state == HI) begin
        hi_q <= p4_q + {15'h0, mid_q[32:16]} + {31'h0, cy_q};
      end
`endif
    end
  end

  always_comb begin
    bus.in_ready   = (state == IDLE) || ((state == OUT) && bus.out_ready);
    bus.out_valid  = (state == OUT);
    bus.busy       = (state != IDLE);
    bus.out_result = '0;
    if (state == OUT) begin
`ifdef MUL_HIGH_EN
      bus.out_result = op_q ? hi_q : lo_q;
`else
      bus.out_result = lo_q;
`endif
    end
  end

endmodule
